// File: rtl/data_bus_if_pkg.sv
`default_nettype none
// ============================================================================
// Module  : data_bus_if_pkg
// Purpose : Shared types and constants for the Wishbone data-side bus bridge.
// Revision: 1.0 - initial release
// ============================================================================
package data_bus_if_pkg;

    localparam int STALL_W       = 6;
    localparam int STALL_MEM_BIT = 4;

    localparam logic [31:0] ZeroWord    = 32'h0000_0000;
    localparam logic        ChipEnable  = 1'b1;
    localparam logic        WriteEnable = 1'b1;

    typedef enum logic [1:0] {
        WB_IDLE           = 2'b00,
        WB_BUSY           = 2'b01,
        WB_WAIT_FOR_STALL = 2'b11
    } wb_state_e;

    // Registered Wishbone master request; cleared as a whole on cycle end.
    typedef struct packed {
        logic [31:0] addr;
        logic [31:0] data;
        logic [3:0]  sel;
        logic        we;
        logic        stb;
        logic        cyc;
    } wb_req_t;

endpackage : data_bus_if_pkg
`default_nettype wire

// File: rtl/data_bus_if.sv
`default_nettype none
// ============================================================================
// Module  : data_bus_if
// Purpose : Runs a MEM-stage request as a Wishbone classic cycle with stall,
//           flush abort and acknowledge timeout.
// Revision: 1.0 - initial release
// ============================================================================
module data_bus_if
    import data_bus_if_pkg::*;
#(
    parameter int ACK_TIMEOUT = 255
) (
    input  logic               clk,
    input  logic               rst,
    input  logic [STALL_W-1:0] stall_i,
    input  logic               flush_i,
    input  logic               cpu_ce_i,
    input  logic               cpu_we_i,
    input  logic [31:0]        cpu_addr_i,
    input  logic [3:0]         cpu_sel_i,
    input  logic [31:0]        cpu_data_i,
    output logic [31:0]        cpu_data_o,
    output logic               stallreq_o,
    output logic               bus_err_o,
    input  logic [31:0]        wb_data_i,
    input  logic               wb_ack_i,
    output logic [31:0]        wb_addr_o,
    output logic [31:0]        wb_data_o,
    output logic [3:0]         wb_sel_o,
    output logic               wb_we_o,
    output logic               wb_stb_o,
    output logic               wb_cyc_o
);

    localparam logic [7:0] TIMEOUT_LAST = 8'(ACK_TIMEOUT - 1);

    wb_state_e   state_q, state_d;
    wb_req_t     wb_q, wb_d;
    logic [7:0]  cnt_q, cnt_d;
    logic [31:0] rd_buf_q, rd_buf_d;
    logic        bus_err_q, bus_err_d;

    logic        w_req;
    logic        w_mem_stall;
    logic        w_unused_stall;

    assign w_req          = (cpu_ce_i == ChipEnable) && !flush_i;
    assign w_mem_stall    = stall_i[STALL_MEM_BIT];
    assign w_unused_stall = ^{stall_i[STALL_W-1:STALL_MEM_BIT+1], stall_i[STALL_MEM_BIT-1:0]};

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q   <= WB_IDLE;
            wb_q      <= '0;
            cnt_q     <= 8'd0;
            rd_buf_q  <= ZeroWord;
            bus_err_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            wb_q      <= wb_d;
            cnt_q     <= cnt_d;
            rd_buf_q  <= rd_buf_d;
            bus_err_q <= bus_err_d;
        end
    end

    always_comb begin
        state_d    = state_q;
        wb_d       = wb_q;
        cnt_d      = cnt_q;
        rd_buf_d   = rd_buf_q;
        bus_err_d  = 1'b0;
        stallreq_o = 1'b0;
        cpu_data_o = ZeroWord;

        case (state_q)
            WB_IDLE: begin
                stallreq_o = w_req;
                if (w_req) begin
                    wb_d.addr = cpu_addr_i;
                    wb_d.data = cpu_data_i;
                    wb_d.sel  = cpu_sel_i;
                    wb_d.we   = cpu_we_i;
                    wb_d.stb  = 1'b1;
                    wb_d.cyc  = 1'b1;
                    cnt_d     = 8'd0;
                    state_d   = WB_BUSY;
                end
            end

            WB_BUSY: begin
                if (flush_i) begin
                    wb_d    = '0;
                    state_d = WB_IDLE;
                end else if (wb_ack_i) begin
                    wb_d = '0;
                    if (wb_q.we != WriteEnable) begin
                        rd_buf_d   = wb_data_i;
                        cpu_data_o = wb_data_i;
                    end
                    state_d = w_mem_stall ? WB_WAIT_FOR_STALL : WB_IDLE;
                end else if (cnt_q == TIMEOUT_LAST) begin
                    wb_d      = '0;
                    bus_err_d = 1'b1;
                    state_d   = WB_IDLE;
                end else begin
                    stallreq_o = 1'b1;
                    cnt_d      = cnt_q + 8'd1;
                end
            end

            // Load data is parked here until ctrl lets the MEM stage advance.
            WB_WAIT_FOR_STALL: begin
                cpu_data_o = rd_buf_q;
                if (flush_i || !w_mem_stall) begin
                    state_d = WB_IDLE;
                end
            end

            default: begin
                wb_d    = '0;
                state_d = WB_IDLE;
            end
        endcase
    end

    assign wb_addr_o = wb_q.addr;
    assign wb_data_o = wb_q.data;
    assign wb_sel_o  = wb_q.sel;
    assign wb_we_o   = wb_q.we;
    assign wb_stb_o  = wb_q.stb;
    assign wb_cyc_o  = wb_q.cyc;
    assign bus_err_o = bus_err_q;

endmodule : data_bus_if
`default_nettype wire
